// File: rtl/coin_input_conditioner.sv
// Synchronizes, debounces and edge-detects four raw coin/button levels, then
// serializes the resulting events into one-hot single-cycle pulses.
module coin_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic nickelIn,
  input  logic dimeIn,
  input  logic joltIn,
  input  logic buzzWaterIn,
  output logic nickel,
  output logic dime,
  output logic jolt,
  output logic buzzWater,
  output logic eventDropped,
  output logic busy
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit 0 is the highest-priority channel (nickel), bit 3 the lowest.
  logic [3:0] raw;
  assign raw = {buzzWaterIn, joltIn, dimeIn, nickelIn};

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       pend_q, pend_d;
  logic [3:0]       out_q;
  logic [3:0]       rise, grant;
  logic             drop_q, drop_d;

  always_comb begin
    deb_d = deb_q;
    rise  = '0;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          deb_d[i] = sync2_q[i];
          rise[i]  = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    if (pend_q[0]) begin
      grant = 4'b0001;
    end else if (pend_q[1]) begin
      grant = 4'b0010;
    end else if (pend_q[2]) begin
      grant = 4'b0100;
    end else if (pend_q[3]) begin
      grant = 4'b1000;
    end
    // A new rise overrides a same-edge grant; a rise onto a waiting flag merges.
    pend_d = (pend_q & ~grant) | rise;
    drop_d = |(rise & pend_q & ~grant);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      pend_q  <= '0;
      out_q   <= '0;
      drop_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      pend_q  <= pend_d;
      out_q   <= grant;
      drop_q  <= drop_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign nickel       = out_q[0];
  assign dime         = out_q[1];
  assign jolt         = out_q[2];
  assign buzzWater    = out_q[3];
  assign eventDropped = drop_q;
  assign busy         = |pend_q;

endmodule
